draw_sprite: RTL and testbench

DRAW_SPRITE -- requirements
Module: draw_sprite

---
 rtl/draw_sprite.sv | 114 +++++++++++
 tb/tb_draw_sprite.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/draw_sprite.sv
// Sprite plotter: scans a SIZE x SIZE bitmap one pixel per clock, rotated by
// direction, emitting x/y/col/plot for a framebuffer write port.
module draw_sprite #(
  parameter int SIZE   = 9,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int COL_W  = 3,
  parameter int BG_COL = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [X_W-1:0]         xpos,
  input  logic [Y_W-1:0]         ypos,
  input  logic [1:0]             direction,
  input  logic                   erase,
  input  logic [COL_W-1:0]       colour,
  input  logic [SIZE*SIZE-1:0]   mask,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COL_W-1:0]       col,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(SIZE);
  localparam int IW = $clog2(SIZE * SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [CW-1:0]        dx, dy;
  logic [X_W-1:0]       xpos_l;
  logic [Y_W-1:0]       ypos_l;
  logic [1:0]           dir_l;
  logic                 erase_l;
  logic [COL_W-1:0]     colour_l;
  logic [SIZE*SIZE-1:0] mask_l;
  logic [IW-1:0]        src_idx;
  logic                 src_bit;

  // Counters stop on the last pixel rather than wrapping, so x/y keep showing
  // the final pixel through DONE and IDLE without extra holding registers.
  always_ff @(posedge clk) begin
    // NOTE: the latched operands are reset too, so x/y/col read 0 after reset.
    if (!resetn) begin
      state    <= IDLE;
      dx       <= '0;
      dy       <= '0;
      xpos_l   <= '0;
      ypos_l   <= '0;
      dir_l    <= '0;
      erase_l  <= 1'b0;
      colour_l <= '0;
      mask_l   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= DRAW;
            dx       <= '0;
            dy       <= '0;
            xpos_l   <= xpos;
            ypos_l   <= ypos;
            dir_l    <= direction;
            erase_l  <= erase;
            colour_l <= colour;
            mask_l   <= mask;
          end
        end
        DRAW: begin
          if (dy == LAST) begin
            if (dx == LAST) begin
              state <= DONE;
            end else begin
              dx <= dx + 1'b1;
              dy <= '0;
            end
          end else begin
            dy <= dy + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Rotation is just a different bitmap index for the same scan order.
  // NOTE: src_idx gets a default first so no latch is inferred.
  always_comb begin
    src_idx = '0;
    case (dir_l)
      2'd0: src_idx = IW'(int'(dy) * SIZE + int'(dx));
      2'd1: src_idx = IW'((SIZE - 1 - int'(dy)) * SIZE + int'(dx));
      2'd2: src_idx = IW'(int'(dx) * SIZE + int'(dy));
      2'd3: src_idx = IW'((SIZE - 1 - int'(dx)) * SIZE + int'(dy));
    endcase
  end

  assign src_bit = mask_l[src_idx];

  assign busy = (state == DRAW);
  assign done = (state == DONE);
  assign plot = busy & (erase_l | src_bit);
  assign x    = xpos_l + X_W'(dx);
  assign y    = ypos_l + Y_W'(dy);
  assign col  = erase_l ? COL_W'(BG_COL) : colour_l;

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite (SIZE=9, BG_COL=2): scan order, rotation,
// erase, wrap-around, mid-draw reset, start blocking and back-to-back draws.
module tb_draw_sprite;

  localparam int BG = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  xpos;
  logic [6:0]  ypos;
  logic [1:0]  direction;
  logic        erase;
  logic [2:0]  colour;
  logic [80:0] mask;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  col;
  logic        plot, busy, done;

  int n_pass = 0;
  int n_total = 0;

  // Results of the most recent run_draw
  int           n_plot, pos_err, col_err, first_k, last_k;
  logic [14:0]  first_xy, last_xy;

  draw_sprite #(
    .SIZE(9), .X_W(8), .Y_W(7), .COL_W(3), .BG_COL(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .xpos(xpos), .ypos(ypos),
    .direction(direction), .erase(erase), .colour(colour), .mask(mask),
    .x(x), .y(y), .col(col), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Starts one draw and follows it to IDLE. Pixel positions and colour are
  // checked every busy cycle against the dx-outer/dy-inner scan order.
  task automatic run_draw(input logic [7:0] xp, input logic [6:0] yp,
                          input logic [1:0] dir, input logic er,
                          input logic [2:0] c, input logic [80:0] m,
                          input bit disturb, input string tag);
    int k;
    logic [2:0] ecol;
    xpos = xp; ypos = yp; direction = dir; erase = er; colour = c; mask = m;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_plot = 0; pos_err = 0; col_err = 0; first_k = -1; last_k = -1;
    first_xy = '0; last_xy = '0;
    ecol = er ? 3'(BG) : c;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      if (x !== 8'(int'(xp) + k / 9) || y !== 7'(int'(yp) + k % 9) || done !== 1'b0)
        pos_err++;
      if (col !== ecol) col_err++;
      if (plot === 1'b1) begin
        n_plot++;
        if (first_k < 0) begin
          first_k  = k;
          first_xy = {x, y};
        end
        last_k  = k;
        last_xy = {x, y};
      end else if (plot !== 1'b0) begin
        pos_err++;
      end
      if (disturb && k == 30) begin
        start = 1'b1; xpos = 8'd0; ypos = 7'd0; direction = ~dir;
        erase = ~er; colour = ~c; mask = ~m;
      end
      tick;
      k++;
    end
    check({tag, " busy cycles"}, k, 81);
    check({tag, " positions"}, pos_err, 0);
    check({tag, " colour"}, col_err, 0);
    check({tag, " done pulse {done,busy,plot}"}, {done, busy, plot}, 3'b100);
    check({tag, " hold xy"}, {x, y}, {8'(int'(xp) + 8), 7'(int'(yp) + 8)});
    tick;
    start = 1'b0;
    check({tag, " idle {done,busy,plot}"}, {done, busy, plot}, 3'b000);
    tick;
    check({tag, " no extra draw"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int k;
    bit  seen;
    int  exp_k [8] = '{0, 8, 0, 72, 9, 17, 1, 73};
    logic [80:0] pat;

    // Reset, with start asserted alongside it
    resetn = 1'b0; start = 1'b1; xpos = 8'd77; ypos = 7'd33; direction = 2'd1;
    erase = 1'b0; colour = 3'd6; mask = '1;
    tick;
    tick;
    check("reset outputs", {busy, done, plot, x, y, col}, 0);
    resetn = 1'b0; start = 1'b0;
    tick;
    resetn = 1'b1;
    tick;
    tick;
    check("idle after reset", {busy, done, plot}, 0);

    // Full sprite, upright
    run_draw(8'd10, 7'd20, 2'd0, 1'b0, 3'd5, '1, 1'b0, "full");
    check("full plots", n_plot, 81);
    check("full first xy", first_xy, {8'd10, 7'd20});
    check("full last xy", last_xy, {8'd18, 7'd28});

    // Single-bit masks through each orientation
    for (int b = 0; b < 2; b++) begin
      for (int d = 0; d < 4; d++) begin
        pat = '0;
        pat[b] = 1'b1;
        run_draw(8'd100, 7'd50, 2'(d), 1'b0, 3'd3, pat, 1'b0, $sformatf("rot b%0d d%0d", b, d));
        check($sformatf("rot b%0d d%0d count", b, d), n_plot, 1);
        check($sformatf("rot b%0d d%0d offset", b, d), last_k, exp_k[b*4+d]);
      end
    end

    // Erase paints everything in background colour regardless of mask
    run_draw(8'd60, 7'd5, 2'd3, 1'b1, 3'd5, '0, 1'b0, "erase");
    check("erase plots", n_plot, 81);

    // Screen-edge wrap-around
    run_draw(8'd250, 7'd125, 2'd0, 1'b0, 3'd7, '1, 1'b0, "wrap");
    check("wrap first xy", first_xy, {8'd250, 7'd125});
    check("wrap last xy", last_xy, {8'd2, 7'd5});

    // Inputs and start disturbed mid-draw
    pat = 81'h1_A5C3_0F0F_1234_5678_9ABC;
    run_draw(8'd33, 7'd44, 2'd2, 1'b0, 3'd4, pat, 1'b1, "disturb");
    check("disturb plots", n_plot, $countones(pat));

    // Reset in the middle of a draw
    xpos = 8'd30; ypos = 7'd40; direction = 2'd0; erase = 1'b0; colour = 3'd6; mask = '1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (40) tick;
    check("midreset before {busy,plot}", {busy, plot}, 2'b11);
    resetn = 1'b0; start = 1'b1;
    tick;
    check("midreset outputs", {busy, done, plot, x, y, col}, 0);
    resetn = 1'b1; start = 1'b0;
    seen = 1'b0;
    repeat (90) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      tick;
    end
    check("midreset quiet", seen, 1'b0);
    run_draw(8'd30, 7'd40, 2'd0, 1'b0, 3'd6, '1, 1'b0, "after reset");
    check("after reset plots", n_plot, 81);

    // Start held high: one DONE and one IDLE cycle between draws
    xpos = 8'd40; ypos = 7'd50; direction = 2'd0; erase = 1'b0; colour = 3'd1; mask = '1;
    start = 1'b1;
    tick;
    check("b2b first busy", busy, 1'b1);
    repeat (81) tick;
    check("b2b done {done,busy}", {done, busy}, 2'b10);
    tick;
    check("b2b idle gap {done,busy}", {done, busy}, 2'b00);
    tick;
    check("b2b second start", {busy, plot, x, y}, {2'b11, 8'd40, 7'd50});
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      tick;
      k++;
    end
    check("b2b second length", k, 81);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
